frame_buf_rd_ctrl: RTL
======================

Name: frame_buf_rd_ctrl

Overview:
- Parametrised N-buffer SDRAM frame-read controller; next generation of the display-side address selector.
- Tracks which frame buffer the writer completed last and, on each display frame start, locks onto that buffer.
- Splits the frame read into fixed-length bursts with a req/ack/done handshake toward the SDRAM read arbiter.
- Sits between the sensor-write path (buffer index and done pulses) and the SDRAM read port feeding the display FIFO.

Parameters:
- SDRAM_ADDRS_DW, 21: SDRAM word-address width.
- IMAGE_WIDE_LENGTH, 256: pixels per line.
- IMAGE_HIGH_LENGTH, 192: lines per frame.
- NUM_BUFS, 3: number of frame buffers, 2..8.
- BUF_STRIDE, 65536: address distance between buffers. Must be >= FRAME_LEN.
- BURST_LEN, 256: words per full burst, 1..FRAME_LEN.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_image_start  in  1  display frame-start level; the rising edge triggers a read.
- i_base_addr  in  SDRAM_ADDRS_DW  address of buffer 0; quasi-static.
- i_wr_done  in  1  one-cycle pulse: the writer finished a buffer.
- i_wr_buf_idx  in  IDX_W  index of the buffer just finished; valid with i_wr_done.
- o_burst_req  out  1  burst request; held until acknowledged.
- o_burst_addr  out  SDRAM_ADDRS_DW  burst start address; stable while o_burst_req is high.
- o_burst_len  out  16  words in this burst; stable while o_burst_req is high.
- i_burst_ack  in  1  arbiter accepted the request.
- i_burst_done  in  1  one-cycle pulse: the last word of the burst has been delivered.
- o_rd_buf_idx  out  IDX_W  buffer being or last read.
- o_busy  out  1  frame read in progress.
- o_frame_done  out  1  one-cycle pulse after the last burst_done.
- o_repeat  out  1  one-cycle pulse at start: no new frame since the previous read.
- o_overrun  out  1  one-cycle pulse: a start edge arrived while busy.
- o_data_length  out  32  FRAME_LEN constant.

Behaviour:
- Derived constants: IDX_W = max(1, clog2(NUM_BUFS)); FRAME_LEN = IMAGE_WIDE_LENGTH * IMAGE_HIGH_LENGTH.
- Reset values: all outputs 0, except o_data_length, which is constant.
- Internal reset values: last_done=0, new_flag=0, state=IDLE.
- i_image_start passes through a 2-flop synchroniser. The edge is taken on pattern 01, so the start is seen 2 cycles after the input rises.
- Write tracking:
  - On i_wr_done: last_done <= i_wr_buf_idx, new_flag <= 1.
  - An index >= NUM_BUFS is ignored; neither register changes.
- State machine, IDLE -> REQ -> WAIT -> (REQ | FIN) -> IDLE.
- IDLE on start edge:
  - rd_idx <= last_done, or i_wr_buf_idx if i_wr_done is in the same cycle (bypass).
  - o_repeat = !new_flag, with the bypass counted as new.
  - new_flag <= 0; o_busy <= 1; remaining <= FRAME_LEN; addr <= i_base_addr + rd_idx*BUF_STRIDE.
  - Next state REQ. A repeat still reads the frame.
- REQ:
  - o_burst_req = 1; o_burst_len = min(BURST_LEN, remaining).
  - On i_burst_ack: drop req, go to WAIT.
  - Latency from start edge to o_burst_req is 1 cycle.
- WAIT:
  - On i_burst_done: addr += len, remaining -= len.
  - If the new remaining is 0, go to FIN; else go to REQ (1-cycle gap).
  - If i_burst_ack and i_burst_done arrive together in REQ, the done is taken as the next cycle's event. The arbiter guarantees done comes at least 1 cycle after ack.
- FIN: o_frame_done = 1 for one cycle; o_busy <= 0; go to IDLE.
- Start edge outside IDLE: the edge is ignored and o_overrun pulses. The current read is unaffected.
- Writes during a read update last_done and new_flag only; rd_idx stays locked until FIN.
- Address arithmetic is modulo 2^SDRAM_ADDRS_DW and wraps silently.
- The last burst is short when FRAME_LEN mod BURST_LEN != 0.
- Asynchronous reset mid-frame returns to IDLE immediately and drops o_burst_req. The downstream arbiter is reset by the same net.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, REQ, WAIT, FIN);
  - the FRAME_LEN and IDX_W functions;
  - the burst-length width constant, 16.
- One natural sub-module, frame_buf_tracker: last_done/new_flag register, bypass and repeat logic. Burst sequencing stays in the top.

Test Plan:
- Small-parameter config: 8x4 frame, BURST_LEN 12, NUM_BUFS 3, BUF_STRIDE 64, base 0x100.
  - Stimulus: wr_done idx 1, then start.
  - Required: bursts (0x140,12), (0x14C,12), (0x158,8), then frame_done; o_repeat=0.
- Second start with no wr_done between.
  - Required: same buffer 1 read again; o_repeat pulses.
- wr_done idx 2 in the same cycle as the synchronised start edge.
  - Required: rd_idx=2, first addr 0x180, no repeat.
- Start edge during the 2nd burst.
  - Required: o_overrun pulses once; burst sequence and addresses unchanged.
- wr_done idx 0 mid-read, then the read completes.
  - Required: remaining bursts stay in buffer 1; the next start reads buffer 0.
- Ack withheld 5 cycles, then reset asserted during WAIT.
  - Required: o_burst_req held stable until ack.
  - Required: on reset, all outputs go to 0 at once; after release the next start begins from a fresh first burst.

Source files
------------

// File: rtl/frame_buf_rd_ctrl_pkg.sv
// Shared types and helpers for the display-side frame-buffer read controller.
// Holds the sequencer state encoding and the derived-size functions.
package frame_buf_rd_ctrl_pkg;

    localparam int BURST_LEN_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_FIN
    } rd_state_e;

    function automatic int frame_len(input int wide, input int high);
        return wide * high;
    endfunction

    // A two-buffer system still needs one index bit.
    function automatic int idx_w(input int nbufs);
        return (nbufs <= 2) ? 1 : $clog2(nbufs);
    endfunction

endpackage

// File: rtl/frame_buf_tracker.sv
// Remembers which buffer the writer finished last and whether it is unread.
// Provides the buffer to lock onto at a frame start, including same-cycle bypass.
module frame_buf_tracker
    import frame_buf_rd_ctrl_pkg::*;
#(
    parameter  int NUM_BUFS = 3,
    localparam int IDX_W    = idx_w(NUM_BUFS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_done_i,
    input  logic [IDX_W-1:0] wr_buf_idx_i,
    input  logic             take_i,
    output logic [IDX_W-1:0] sel_idx_o,
    output logic             is_repeat_o
);

    logic [IDX_W-1:0] last_done_q, last_done_d;
    logic             new_flag_q, new_flag_d;
    logic             wr_valid;

    // Out-of-range indices come from a misconfigured writer and are dropped.
    assign wr_valid    = wr_done_i && (32'(wr_buf_idx_i) < 32'(NUM_BUFS));
    assign sel_idx_o   = wr_valid ? wr_buf_idx_i : last_done_q;
    assign is_repeat_o = !(wr_valid || new_flag_q);

    always_comb begin
        last_done_d = last_done_q;
        new_flag_d  = new_flag_q;
        if (wr_valid) begin
            last_done_d = wr_buf_idx_i;
            new_flag_d  = 1'b1;
        end
        // A bypassed write is consumed by the start that sees it.
        if (take_i) begin
            new_flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_done_q <= '0;
            new_flag_q  <= 1'b0;
        end else begin
            last_done_q <= last_done_d;
            new_flag_q  <= new_flag_d;
        end
    end

endmodule

// File: rtl/frame_buf_rd_ctrl.sv
// N-buffer SDRAM frame-read controller: locks onto the newest written buffer at
// each display frame start and reads it as a sequence of req/ack/done bursts.
module frame_buf_rd_ctrl
    import frame_buf_rd_ctrl_pkg::*;
#(
    parameter  int SDRAM_ADDRS_DW    = 21,
    parameter  int IMAGE_WIDE_LENGTH = 256,
    parameter  int IMAGE_HIGH_LENGTH = 192,
    parameter  int NUM_BUFS          = 3,
    parameter  int BUF_STRIDE        = 65536,
    parameter  int BURST_LEN         = 256,
    localparam int IDX_W             = idx_w(NUM_BUFS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_image_start,
    input  logic [SDRAM_ADDRS_DW-1:0] i_base_addr,
    input  logic                      i_wr_done,
    input  logic [IDX_W-1:0]          i_wr_buf_idx,
    output logic                      o_burst_req,
    output logic [SDRAM_ADDRS_DW-1:0] o_burst_addr,
    output logic [BURST_LEN_W-1:0]    o_burst_len,
    input  logic                      i_burst_ack,
    input  logic                      i_burst_done,
    output logic [IDX_W-1:0]          o_rd_buf_idx,
    output logic                      o_busy,
    output logic                      o_frame_done,
    output logic                      o_repeat,
    output logic                      o_overrun,
    output logic [31:0]               o_data_length
);

    localparam int FRAME_LEN = frame_len(IMAGE_WIDE_LENGTH, IMAGE_HIGH_LENGTH);
    localparam logic [SDRAM_ADDRS_DW-1:0] STRIDE_A = SDRAM_ADDRS_DW'(BUF_STRIDE);

    rd_state_e                 state_q, state_d;
    logic [2:0]                sync_q;
    logic [IDX_W-1:0]          rd_idx_q, rd_idx_d;
    logic [SDRAM_ADDRS_DW-1:0] addr_q, addr_d;
    logic [31:0]               remaining_q, remaining_d;
    logic                      pend_done_q, pend_done_d;
    logic                      repeat_q, repeat_d;
    logic                      overrun_q, overrun_d;
    logic                      start_edge;
    logic                      take;
    logic [IDX_W-1:0]          sel_idx;
    logic                      is_repeat;
    logic [BURST_LEN_W-1:0]    cur_len;

    // Two synchroniser stages plus one history stage for the 0->1 detect.
    assign start_edge = sync_q[1] && !sync_q[2];
    assign take       = start_edge && (state_q == ST_IDLE);

    assign cur_len = (remaining_q < 32'(BURST_LEN)) ? remaining_q[BURST_LEN_W-1:0]
                                                    : BURST_LEN_W'(BURST_LEN);

    frame_buf_tracker #(
        .NUM_BUFS (NUM_BUFS)
    ) u_tracker (
        .clk_i        (i_clk),
        .rst_ni       (i_rst_n),
        .wr_done_i    (i_wr_done),
        .wr_buf_idx_i (i_wr_buf_idx),
        .take_i       (take),
        .sel_idx_o    (sel_idx),
        .is_repeat_o  (is_repeat)
    );

    always_comb begin
        state_d     = state_q;
        rd_idx_d    = rd_idx_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        pend_done_d = pend_done_q;
        repeat_d    = 1'b0;
        overrun_d   = start_edge && (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    rd_idx_d    = sel_idx;
                    repeat_d    = is_repeat;
                    remaining_d = 32'(FRAME_LEN);
                    addr_d      = i_base_addr + SDRAM_ADDRS_DW'(sel_idx) * STRIDE_A;
                    pend_done_d = 1'b0;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                // A done coincident with the ack is replayed in WAIT.
                if (i_burst_ack) begin
                    pend_done_d = i_burst_done;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_burst_done || pend_done_q) begin
                    pend_done_d = 1'b0;
                    addr_d      = addr_q + SDRAM_ADDRS_DW'(cur_len);
                    remaining_d = remaining_q - 32'(cur_len);
                    state_d     = (remaining_q == 32'(cur_len)) ? ST_FIN : ST_REQ;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            sync_q      <= '0;
            rd_idx_q    <= '0;
            addr_q      <= '0;
            remaining_q <= '0;
            pend_done_q <= 1'b0;
            repeat_q    <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[1:0], i_image_start};
            rd_idx_q    <= rd_idx_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            pend_done_q <= pend_done_d;
            repeat_q    <= repeat_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_burst_req   = (state_q == ST_REQ);
    assign o_burst_addr  = addr_q;
    assign o_burst_len   = cur_len;
    assign o_rd_buf_idx  = rd_idx_q;
    assign o_busy        = (state_q != ST_IDLE);
    assign o_frame_done  = (state_q == ST_FIN);
    assign o_repeat      = repeat_q;
    assign o_overrun     = overrun_q;
    assign o_data_length = 32'(FRAME_LEN);

endmodule
